// File: rtl/line_raster_engine.sv
// Bresenham line rasteriser: accepts one line op, streams one (x,y,colour) beat per
// visible pixel with per-pixel dash pattern and viewport clipping, then pulses done.
module line_raster_engine #(
  parameter int unsigned XW   = 10,
  parameter int unsigned YW   = 10,
  parameter int unsigned CW   = 12,
  parameter int unsigned XMAX = 639,
  parameter int unsigned YMAX = 479,
  parameter int unsigned PATW = 16
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [XW-1:0]   in_x1,
  input  logic [YW-1:0]   in_y1,
  input  logic [XW-1:0]   in_x2,
  input  logic [YW-1:0]   in_y2,
  input  logic [CW-1:0]   in_color,
  input  logic [PATW-1:0] in_pattern,
  input  logic            in_clip,
  input  logic            in_rts,
  output logic            in_rtr,
  output logic [XW-1:0]   out_x,
  output logic [YW-1:0]   out_y,
  output logic [CW-1:0]   out_color,
  output logic            out_rts,
  input  logic            out_rtr,
  output logic            busy,
  output logic            done
);

  localparam int unsigned MW = (XW > YW) ? XW : YW;
  localparam int unsigned EW = MW + 2;
  localparam int unsigned IW = (PATW > 1) ? $clog2(PATW) : 1;
  localparam logic [XW-1:0] XLIM = XW'(XMAX);
  localparam logic [YW-1:0] YLIM = YW'(YMAX);
  localparam logic [IW-1:0] IDX_LAST = IW'(PATW - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STEP, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [XW-1:0]        x2_q, x2_d, cx_q, cx_d, dx_q, dx_d;
  logic [YW-1:0]        y2_q, y2_d, cy_q, cy_d, dy_q, dy_d;
  logic [CW-1:0]        color_q, color_d;
  logic [PATW-1:0]      pattern_q, pattern_d;
  logic                 clip_q, clip_d;
  logic                 sxn_q, sxn_d, syn_q, syn_d;
  logic signed [EW-1:0] err_q, err_d;
  logic [IW-1:0]        idx_q, idx_d;

  logic [XW-1:0]        dx_new;
  logic [YW-1:0]        dy_new;
  logic                 vis;
  logic                 at_end;
  logic signed [EW:0]   dx_w, dy_w, e2, err_w, sub_w, add_w;
  logic                 step_x, step_y;

  // Setup-time deltas, measured from the start point held in cx/cy
  assign dx_new = (x2_q >= cx_q) ? (x2_q - cx_q) : (cx_q - x2_q);
  assign dy_new = (y2_q >= cy_q) ? (y2_q - cy_q) : (cy_q - y2_q);

  assign vis    = pattern_q[idx_q] && (!clip_q || ((cx_q <= XLIM) && (cy_q <= YLIM)));
  assign at_end = (cx_q == x2_q) && (cy_q == y2_q);

  // Error-term decision uses one extra bit so 2*err never overflows
  assign dx_w   = signed'((EW+1)'(dx_q));
  assign dy_w   = signed'((EW+1)'(dy_q));
  assign e2     = signed'({err_q, 1'b0});
  assign step_x = e2 > -dy_w;
  assign step_y = e2 < dx_w;
  assign sub_w  = step_x ? dy_w : '0;
  assign add_w  = step_y ? dx_w : '0;
  assign err_w  = {err_q[EW-1], err_q} - sub_w + add_w;

  always_comb begin
    state_d   = state_q;
    x2_d      = x2_q;
    y2_d      = y2_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    color_d   = color_q;
    pattern_d = pattern_q;
    clip_d    = clip_q;
    sxn_d     = sxn_q;
    syn_d     = syn_q;
    err_d     = err_q;
    idx_d     = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_rts) begin
          cx_d      = in_x1;
          cy_d      = in_y1;
          x2_d      = in_x2;
          y2_d      = in_y2;
          color_d   = in_color;
          pattern_d = in_pattern;
          clip_d    = in_clip;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        dx_d    = dx_new;
        dy_d    = dy_new;
        sxn_d   = x2_q < cx_q;
        syn_d   = y2_q < cy_q;
        err_d   = signed'(EW'(dx_new)) - signed'(EW'(dy_new));
        idx_d   = '0;
        state_d = S_STEP;
      end
      S_STEP: begin
        // Invisible pixels retire unconditionally; visible ones wait for the sink
        if (!vis || out_rtr) begin
          if (at_end) begin
            state_d = S_DONE;
          end else begin
            err_d = err_w[EW-1:0];
            if (step_x) cx_d = sxn_q ? (cx_q - XW'(1)) : (cx_q + XW'(1));
            if (step_y) cy_d = syn_q ? (cy_q - YW'(1)) : (cy_q + YW'(1));
            idx_d = (idx_q == IDX_LAST) ? '0 : (idx_q + IW'(1));
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q   <= S_IDLE;
      x2_q      <= '0;
      y2_q      <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      color_q   <= '0;
      pattern_q <= '0;
      clip_q    <= 1'b0;
      sxn_q     <= 1'b0;
      syn_q     <= 1'b0;
      err_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      x2_q      <= x2_d;
      y2_q      <= y2_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      color_q   <= color_d;
      pattern_q <= pattern_d;
      clip_q    <= clip_d;
      sxn_q     <= sxn_d;
      syn_q     <= syn_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
    end
  end

  assign in_rtr    = (state_q == S_IDLE) && rst_;
  assign out_rts   = (state_q == S_STEP) && vis;
  assign out_x     = cx_q;
  assign out_y     = cy_q;
  assign out_color = color_q;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;

endmodule
